// File: rtl/sram_mem_responder.sv
// Multi-cycle memory responder for the MEM stage load/store handshake.
// Each 32-bit word is stored as two 16-bit halfwords, low half first.
module sram_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 17,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic        ready,
    output logic [31:0] rd_data
);

    localparam int unsigned WordBits = ADDR_WIDTH - 1;
    localparam logic [3:0]  LastCnt  = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_op_q, in_range_q;
    logic [WordBits-1:0]   idx_q;
    logic [31:0]           wdata_q;
    logic [15:0]           lo_q;
    logic [31:0]           rd_data_q;

    logic [15:0] mem [2**ADDR_WIDTH];

    logic                  req;
    logic [31:0]           diff;
    logic [WordBits-1:0]   req_idx;
    logic                  req_in_range;
    logic                  last;
    logic                  capture;
    logic                  lo_commit, hi_commit;
    logic [ADDR_WIDTH-1:0] lo_addr, hi_addr;
    logic [15:0]           lo_half, hi_half;
    logic                  unused_diff;

    assign req          = MEM_R_EN | MEM_W_EN;
    // Modular subtraction: addresses below the base wrap to a huge index.
    assign diff         = addr - 32'(BASE_ADDR);
    assign req_idx      = diff[ADDR_WIDTH:2];
    assign req_in_range = (diff[31:ADDR_WIDTH+1] == '0);
    assign unused_diff  = ^diff[1:0];

    assign last      = (cnt_q == LastCnt);
    assign capture   = (state_q == StIdle) && req;
    assign lo_commit = (state_q == StLo) && last;
    assign hi_commit = (state_q == StHi) && last;
    assign lo_addr   = {idx_q, 1'b0};
    assign hi_addr   = {idx_q, 1'b1};
    assign lo_half   = in_range_q ? mem[lo_addr] : 16'h0000;
    assign hi_half   = in_range_q ? mem[hi_addr] : 16'h0000;

    // Held high during reset so the pipeline is never frozen by a dead responder.
    assign ready   = ~rst | ((state_q == StIdle) && ~req) | (state_q == StDone);
    assign rd_data = rd_data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StLo;
                    cnt_d   = 4'd0;
                end
            end
            StLo: begin
                if (last) begin
                    state_d = StHi;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHi: begin
                if (last) begin
                    state_d = StDone;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: state_d = StIdle;
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            wr_op_q    <= 1'b0;
            in_range_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'h0;
            lo_q       <= 16'h0;
            rd_data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                wr_op_q    <= MEM_W_EN;
                in_range_q <= req_in_range;
                idx_q      <= req_idx;
                wdata_q    <= wr_data;
            end
            if (lo_commit && !wr_op_q) begin
                lo_q <= lo_half;
            end
            if (hi_commit && !wr_op_q) begin
                rd_data_q <= {hi_half, lo_q};
            end
        end
    end

    // Array is not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (lo_commit && wr_op_q && in_range_q) begin
            mem[lo_addr] <= wdata_q[15:0];
        end
        if (hi_commit && wr_op_q && in_range_q) begin
            mem[hi_addr] <= wdata_q[31:16];
        end
    end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed bench for sram_mem_responder: one instance at WAIT_CYCLES=2, one at 1,
// sharing the request inputs.
module tb_sram_mem_responder;

    logic        clk;
    logic        rst;
    logic        r_en, w_en;
    logic [31:0] addr, wdata;
    logic        ready_a, ready_b;
    logic [31:0] rd_a, rd_b;

    int n_checks;
    int n_fail;

    sram_mem_responder #(
        .ADDR_WIDTH (17),
        .WAIT_CYCLES(2),
        .BASE_ADDR  (1024)
    ) dut_a (
        .clk     (clk),
        .rst     (rst),
        .MEM_R_EN(r_en),
        .MEM_W_EN(w_en),
        .addr    (addr),
        .wr_data (wdata),
        .ready   (ready_a),
        .rd_data (rd_a)
    );

    sram_mem_responder #(
        .ADDR_WIDTH (17),
        .WAIT_CYCLES(1),
        .BASE_ADDR  (1024)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .MEM_R_EN(r_en),
        .MEM_W_EN(w_en),
        .addr    (addr),
        .wr_data (wdata),
        .ready   (ready_b),
        .rd_data (rd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Starts at the next falling edge; returns #1 into the DONE cycle with inputs still held.
    task automatic access(input bit sel, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d, output int low);
        @(negedge clk);
        r_en  = r;
        w_en  = w;
        addr  = a;
        wdata = d;
        low   = 0;
        #1;
        while (((sel ? ready_b : ready_a) == 1'b0) && (low < 50)) begin
            low++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic go_idle(input bit sel, input string tag);
        @(negedge clk);
        r_en = 1'b0;
        w_en = 1'b0;
        #1;
        check_eq(tag, 32'(sel ? ready_b : ready_a), 32'd1);
    endtask

    initial begin
        int low;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b0;
        r_en  = 1'b0;
        w_en  = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;

        #2;
        check_eq("reset_ready_a", 32'(ready_a), 32'd1);
        check_eq("reset_rd_a", rd_a, 32'h0);
        check_eq("reset_ready_b", 32'(ready_b), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Store then load
        access(1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, low);
        check_eq("wr1024_lat", 32'(low), 32'd5);
        go_idle(1'b0, "idle_after_wr");
        access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, low);
        check_eq("rd1024_lat", 32'(low), 32'd5);
        check_eq("rd1024_data", rd_a, 32'hDEADBEEF);
        go_idle(1'b0, "idle_after_rd");
        check_eq("rd_hold_idle", rd_a, 32'hDEADBEEF);

        // Back-to-back, requests held across DONE
        access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h11112222, low);
        check_eq("b2b_wr1028_lat", 32'(low), 32'd5);
        access(1'b0, 1'b0, 1'b1, 32'd1032, 32'h33334444, low);
        check_eq("b2b_wr1032_lat", 32'(low), 32'd5);
        check_eq("rd_hold_wr", rd_a, 32'hDEADBEEF);
        access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, low);
        check_eq("b2b_rd1028_lat", 32'(low), 32'd5);
        check_eq("b2b_rd1028", rd_a, 32'h11112222);
        access(1'b0, 1'b1, 1'b0, 32'd1032, 32'h0, low);
        check_eq("b2b_rd1032_lat", 32'(low), 32'd5);
        check_eq("b2b_rd1032", rd_a, 32'h33334444);
        go_idle(1'b0, "idle_after_b2b");

        // Reset during the HI phase of a write
        access(1'b0, 1'b0, 1'b1, 32'd1036, 32'hAAAABBBB, low);
        go_idle(1'b0, "idle_pre_rst");
        @(negedge clk);
        r_en  = 1'b0;
        w_en  = 1'b1;
        addr  = 32'd1036;
        wdata = 32'h12345678;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_ready", 32'(ready_a), 32'd1);
        check_eq("midrst_rd", rd_a, 32'h0);
        w_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        access(1'b0, 1'b1, 1'b0, 32'd1036, 32'h0, low);
        check_eq("midrst_rd1036", rd_a, 32'hAAAA5678);
        go_idle(1'b0, "idle_post_rst");

        // Out of range: 512 wraps onto the same truncated index as 0x40200
        access(1'b0, 1'b0, 1'b1, 32'h0004_0200, 32'h5A5A5A5A, low);
        access(1'b0, 1'b1, 1'b0, 32'h0004_0200, 32'h0, low);
        check_eq("alias_rd", rd_a, 32'h5A5A5A5A);
        access(1'b0, 1'b0, 1'b1, 32'd512, 32'hFFFFFFFF, low);
        check_eq("oor_wr_lat", 32'(low), 32'd5);
        access(1'b0, 1'b1, 1'b0, 32'd512, 32'h0, low);
        check_eq("oor_rd_lat", 32'(low), 32'd5);
        check_eq("oor_rd", rd_a, 32'h0);
        access(1'b0, 1'b1, 1'b0, 32'h0004_0200, 32'h0, low);
        check_eq("alias_unchanged", rd_a, 32'h5A5A5A5A);

        // Both enables act as a write
        access(1'b0, 1'b0, 1'b1, 32'd1044, 32'h00000001, low);
        access(1'b0, 1'b1, 1'b0, 32'd1044, 32'h0, low);
        check_eq("rd_one", rd_a, 32'h1);
        access(1'b0, 1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, low);
        check_eq("both_lat", 32'(low), 32'd5);
        check_eq("both_rd_kept", rd_a, 32'h1);
        access(1'b0, 1'b1, 1'b0, 32'd1040, 32'h0, low);
        check_eq("both_rd1040", rd_a, 32'hCAFEF00D);
        go_idle(1'b0, "idle_after_both");

        // WAIT_CYCLES=1 instance and misaligned address
        repeat (12) @(negedge clk);
        access(1'b1, 1'b0, 1'b1, 32'd1024, 32'h01020304, low);
        check_eq("b_wr_lat", 32'(low), 32'd3);
        go_idle(1'b1, "b_idle_after_wr");
        access(1'b1, 1'b1, 1'b0, 32'd1027, 32'h0, low);
        check_eq("b_rd_lat", 32'(low), 32'd3);
        check_eq("b_misaligned_rd", rd_b, 32'h01020304);
        go_idle(1'b1, "b_idle_after_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
